// File: rtl/pattern_stream_source_if.sv
// Byte bus between the pattern stream source and the pattern detector.
interface pattern_stream_source_if;
    logic [7:0] data;
    logic       ack;
    logic       found_pattern;

    modport master (output data, output ack, input found_pattern);
    modport slave  (input data, input ack, output found_pattern);
endinterface

// File: rtl/pattern_stream_source.sv
// Sends one 4-byte pattern frame per start request (optionally corrupted), waits for
// the detector's found_pattern, runs the ack release handshake, and tallies hits/misses.
module pattern_stream_source #(
    parameter logic [7:0] P0             = 8'h62,
    parameter logic [7:0] P1             = 8'h6F,
    parameter logic [7:0] P2             = 8'h6D,
    parameter logic [7:0] P3             = 8'h62,
    parameter logic [7:0] FILL_BYTE      = 8'h00,
    parameter int         TIMEOUT        = 8,
    parameter int         ACK_LOW_CYCLES = 2,
    parameter int         CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    reset_sync,
    input  logic                    start,
    input  logic [2:0]              corrupt_idx,
    pattern_stream_source_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic                    error
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_FOUND,
        ACK_LOW,
        ACK_REL,
        FINISH
    } state_t;

    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_LAST = 8'(ACK_LOW_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [7:0] tmr, tmr_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] corrupt, corrupt_n;
    logic       expect_hit, expect_hit_n;
    logic       hit_inc, miss_inc, err_set;
    logic [7:0] data_n;
    logic       ack_n, busy_n, done_n;

    function automatic logic [7:0] pattern_byte(input logic [1:0] i);
        case (i)
            2'd0:    pattern_byte = P0;
            2'd1:    pattern_byte = P1;
            2'd2:    pattern_byte = P2;
            default: pattern_byte = P3;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        tmr_n        = tmr;
        cnt_n        = cnt;
        corrupt_n    = corrupt;
        expect_hit_n = expect_hit;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        err_set      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = SEND;
                    idx_n        = 2'd0;
                    corrupt_n    = corrupt_idx;
                    expect_hit_n = corrupt_idx[2];
                end
            end
            SEND: begin
                if (idx == 2'd3) begin
                    state_n = WAIT_FOUND;
                    tmr_n   = 8'd0;
                end else begin
                    idx_n = idx + 2'd1;
                end
            end
            WAIT_FOUND: begin
                if (bus.found_pattern) begin
                    hit_inc = 1'b1;
                    err_set = !expect_hit;
                    state_n = ACK_LOW;
                    cnt_n   = 8'd0;
                end else if (tmr == TMR_LAST) begin
                    miss_inc = 1'b1;
                    err_set  = expect_hit;
                    state_n  = FINISH;
                end else begin
                    tmr_n = tmr + 8'd1;
                end
            end
            ACK_LOW: begin
                if (cnt == CNT_LAST) begin
                    state_n = ACK_REL;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ACK_REL: state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are computed from the next state so the registered values line up with it.
        data_n = FILL_BYTE;
        if (state_n == SEND) begin
            data_n = pattern_byte(idx_n) ^ {7'd0, ({1'b0, idx_n} == corrupt_n)};
        end
        ack_n  = (state_n != ACK_LOW);
        busy_n = (state_n != IDLE);
        done_n = (state_n == FINISH);
    end

    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            state      <= IDLE;
            idx        <= 2'd0;
            tmr        <= 8'd0;
            cnt        <= 8'd0;
            corrupt    <= 3'd7;
            expect_hit <= 1'b1;
            bus.data   <= FILL_BYTE;
            bus.ack    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            tmr        <= tmr_n;
            cnt        <= cnt_n;
            corrupt    <= corrupt_n;
            expect_hit <= expect_hit_n;
            bus.data   <= data_n;
            bus.ack    <= ack_n;
            busy       <= busy_n;
            done       <= done_n;
            if (hit_inc)  hit_count  <= sat_inc(hit_count);
            if (miss_inc) miss_count <= sat_inc(miss_count);
            if (err_set)  error      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pattern_stream_source.sv
// Directed bench for pattern_stream_source with a small behavioural detector on the bus.
module tb_pattern_stream_source;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] corrupt_idx;
    logic       busy, done, error;
    logic [7:0] hit_count, miss_count;

    logic        use_model;
    logic        model_found;
    logic        det_found;
    logic        seen_low;
    logic [31:0] shreg;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt;

    pattern_stream_source_if bus ();

    pattern_stream_source dut (
        .clk         (clk),
        .reset_sync  (rst_n),
        .start       (start),
        .corrupt_idx (corrupt_idx),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .error       (error)
    );

    always #5 clk = ~clk;

    assign bus.found_pattern = use_model ? model_found : det_found;

    // Detector: raises found after seeing "bomb", drops it after ack goes low then high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= 32'd0;
            det_found <= 1'b0;
            seen_low  <= 1'b0;
        end else begin
            shreg <= {shreg[23:0], bus.data};
            if (!det_found) begin
                if ({shreg[23:0], bus.data} == 32'h626F6D62) det_found <= 1'b1;
            end else if (!bus.ack) begin
                seen_low <= 1'b1;
            end else if (seen_low) begin
                det_found <= 1'b0;
                seen_low  <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [2:0] c);
        start       = 1'b1;
        corrupt_idx = c;
        tick();
        start       = 1'b0;
        corrupt_idx = 3'd7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; corrupt_idx = 3'd7; use_model = 1'b0; model_found = 1'b0;
        repeat (2) tick();
        chk("rst_data", bus.data, 8'h00);
        chk("rst_ack", bus.ack, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_data", bus.data, 8'h00);
        chk("idle_ack", bus.ack, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_hit", hit_count, 8'd0);
        chk("idle_miss", miss_count, 8'd0);
        chk("idle_err", error, 1'b0);

        // Clean frame with the detector attached
        start_frame(3'd7);
        chk("hit_b0", bus.data, 8'h62);
        chk("hit_busy", busy, 1'b1);
        tick(); chk("hit_b1", bus.data, 8'h6F);
        tick(); chk("hit_b2", bus.data, 8'h6D);
        tick(); chk("hit_b3", bus.data, 8'h62);
        chk("hit_found_p3", bus.found_pattern, 1'b0);
        tick(); chk("hit_wait_data", bus.data, 8'h00);
        chk("hit_found", bus.found_pattern, 1'b1);
        chk("hit_wait_ack", bus.ack, 1'b1);
        tick(); chk("hit_ack_low0", bus.ack, 1'b0);
        chk("hit_cnt_early", hit_count, 8'd1);
        tick(); chk("hit_ack_low1", bus.ack, 1'b0);
        tick(); chk("hit_ack_rel", bus.ack, 1'b1);
        chk("hit_done_early", done, 1'b0);
        tick(); chk("hit_done", done, 1'b1);
        chk("hit_busy_fin", busy, 1'b1);
        chk("hit_hit", hit_count, 8'd1);
        chk("hit_miss", miss_count, 8'd0);
        chk("hit_err", error, 1'b0);
        chk("det_idle", {30'd0, det_found, seen_low}, 32'd0);
        tick(); chk("hit_done_clr", done, 1'b0);
        chk("hit_busy_clr", busy, 1'b0);

        // Corrupted third byte: detector stays silent, frame times out
        start_frame(3'd2);
        chk("miss_b0", bus.data, 8'h62);
        tick(); chk("miss_b1", bus.data, 8'h6F);
        tick(); chk("miss_b2", bus.data, 8'h6C);
        tick(); chk("miss_b3", bus.data, 8'h62);
        tick(); chk("miss_found", bus.found_pattern, 1'b0);
        repeat (7) tick();
        chk("miss_done_early", done, 1'b0);
        chk("miss_cnt_early", miss_count, 8'd0);
        tick(); chk("miss_done", done, 1'b1);
        chk("miss_miss", miss_count, 8'd1);
        chk("miss_hit", hit_count, 8'd1);
        chk("miss_err", error, 1'b0);
        tick(); chk("miss_busy_clr", busy, 1'b0);

        // Forced found on a corrupted frame: unexpected hit sets error
        use_model = 1'b1; model_found = 1'b1;
        start_frame(3'd0);
        chk("force_b0", bus.data, 8'h63);
        chk("force_send_ignore", hit_count, 8'd1);
        repeat (4) tick();
        tick(); chk("force_hit", hit_count, 8'd2);
        chk("force_err", error, 1'b1);
        chk("force_ack", bus.ack, 1'b0);
        repeat (3) tick();
        chk("force_done", done, 1'b1);
        tick();
        use_model = 1'b0; model_found = 1'b0;
        start_frame(3'd7);
        repeat (8) tick();
        chk("sticky_done", done, 1'b1);
        chk("sticky_hit", hit_count, 8'd3);
        chk("sticky_err", error, 1'b1);
        tick();

        // Start pulses while busy are dropped
        start_frame(3'd7);
        done_cnt = 0;
        for (int n = 2; n <= 16; n++) begin
            tick();
            done_cnt += int'(done);
            if (n == 6) chk("ign_ack_low", bus.ack, 1'b0);
            start = (n == 2) || (n == 6);
        end
        start = 1'b0;
        chk("ign_done_cnt", done_cnt, 32'd1);
        chk("ign_hit", hit_count, 8'd4);
        chk("ign_busy", busy, 1'b0);
        chk("ign_miss", miss_count, 8'd1);

        // Asynchronous reset during ACK_LOW
        start_frame(3'd7);
        repeat (5) tick();
        chk("ar_ack_low", bus.ack, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ack", bus.ack, 1'b1);
        chk("ar_data", bus.data, 8'h00);
        chk("ar_busy", busy, 1'b0);
        chk("ar_hit", hit_count, 8'd0);
        chk("ar_miss", miss_count, 8'd0);
        chk("ar_err", error, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(3'd7);
        chk("post_b0", bus.data, 8'h62);
        repeat (3) tick();
        chk("post_b3", bus.data, 8'h62);
        tick(); chk("post_found", bus.found_pattern, 1'b1);
        repeat (4) tick();
        chk("post_done", done, 1'b1);
        chk("post_hit", hit_count, 8'd1);
        chk("post_err", error, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
